// File: rtl/reset_sequencer.sv
// Power-up / recovery reset sequencer: waits for stable PLL lock, then releases
// NUM_STAGES reset domains in order, each gated on its own synchronised done ack.
module reset_sequencer #(
    parameter int NUM_STAGES     = 3,
    parameter int HOLD_CYCLES    = 16,
    parameter int SETTLE_CYCLES  = 64,
    parameter int GAP_CYCLES     = 8,
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int MAX_RETRY      = 3,
    parameter int SYNC_STAGES    = 3,
    parameter int CNT_W          = 16
) (
    input  logic                  clk,
    input  logic                  resetn_async,
    input  logic                  pll_locked,
    input  logic [NUM_STAGES-1:0] stage_done,
    input  logic                  sw_reset_req,
    output logic [NUM_STAGES-1:0] stage_resetn,
    output logic                  seq_done,
    output logic                  seq_fault,
    output logic [2:0]            seq_state,
    output logic [1:0]            retry_cnt
);

    localparam int IDX_W = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;

    typedef enum logic [2:0] {
        S_RESET_ALL = 3'd0,
        S_WAIT_LOCK = 3'd1,
        S_SETTLE    = 3'd2,
        S_RELEASE   = 3'd3,
        S_WAIT_DONE = 3'd4,
        S_GAP       = 3'd5,
        S_DONE      = 3'd6,
        S_FAULT     = 3'd7
    } state_e;

    state_e                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [1:0]            retry_q, retry_d, retry_inc;
    logic [NUM_STAGES-1:0] rstn_q, rstn_d;
    logic                  done_q, done_d;
    logic                  fault_q, fault_d;
    logic                  locked_s, lock_lost;
    logic [NUM_STAGES-1:0] done_s;

    (* ASYNC_REG = "TRUE" *) logic [SYNC_STAGES-1:0] lock_sync_q;

    always_ff @(posedge clk or negedge resetn_async) begin
        if (!resetn_async) lock_sync_q <= '0;
        else               lock_sync_q <= {lock_sync_q[SYNC_STAGES-2:0], pll_locked};
    end
    assign locked_s = lock_sync_q[SYNC_STAGES-1];

    for (genvar i = 0; i < NUM_STAGES; i++) begin : g_done_sync
        (* ASYNC_REG = "TRUE" *) logic [SYNC_STAGES-1:0] sync_q;
        always_ff @(posedge clk or negedge resetn_async) begin
            if (!resetn_async) sync_q <= '0;
            else               sync_q <= {sync_q[SYNC_STAGES-2:0], stage_done[i]};
        end
        assign done_s[i] = sync_q[SYNC_STAGES-1];
    end

    always_ff @(posedge clk or negedge resetn_async) begin
        if (!resetn_async) begin
            state_q <= S_RESET_ALL;
            cnt_q   <= '0;
            idx_q   <= '0;
            retry_q <= '0;
            rstn_q  <= '0;
            done_q  <= 1'b0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            retry_q <= retry_d;
            rstn_q  <= rstn_d;
            done_q  <= done_d;
            fault_q <= fault_d;
        end
    end

    assign retry_inc = (retry_q == 2'd3) ? 2'd3 : retry_q + 2'd1;
    assign lock_lost = !locked_s &&
                       (state_q inside {S_RELEASE, S_WAIT_DONE, S_GAP, S_DONE});

    // Priority: sw request, lock loss, then per-state timeout/done/terminal count.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        retry_d = retry_q;
        if (sw_reset_req) begin
            state_d = S_RESET_ALL;
            cnt_d   = '0;
            retry_d = '0;
        end else if (lock_lost) begin
            state_d = S_RESET_ALL;
            cnt_d   = '0;
        end else begin
            case (state_q)
                S_RESET_ALL: begin
                    if (cnt_q == CNT_W'(HOLD_CYCLES - 1)) begin
                        state_d = S_WAIT_LOCK;
                        cnt_d   = '0;
                        idx_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                S_WAIT_LOCK: begin
                    if (locked_s) begin
                        state_d = S_SETTLE;
                        cnt_d   = '0;
                    end
                end
                S_SETTLE: begin
                    if (!locked_s) begin
                        state_d = S_WAIT_LOCK;
                        cnt_d   = '0;
                    end else if (cnt_q == CNT_W'(SETTLE_CYCLES - 1)) begin
                        state_d = S_RELEASE;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                S_RELEASE: begin
                    state_d = S_WAIT_DONE;
                    cnt_d   = '0;
                end
                S_WAIT_DONE: begin
                    if (done_s[idx_q]) begin
                        if (idx_q == IDX_W'(NUM_STAGES - 1)) begin
                            state_d = S_DONE;
                        end else begin
                            state_d = S_GAP;
                            cnt_d   = '0;
                        end
                    end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                        retry_d = retry_inc;
                        if (int'(retry_inc) >= MAX_RETRY) begin
                            state_d = S_FAULT;
                        end else begin
                            state_d = S_RESET_ALL;
                            cnt_d   = '0;
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                S_GAP: begin
                    if (cnt_q == CNT_W'(GAP_CYCLES - 1)) begin
                        state_d = S_RELEASE;
                        idx_d   = idx_q + IDX_W'(1);
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    // Registered outputs follow the state being entered, so a release edge
    // raises stage_resetn[idx] together with the move into WAIT_DONE.
    always_comb begin
        rstn_d  = rstn_q;
        done_d  = (state_d == S_DONE);
        fault_d = (state_d == S_FAULT);
        case (state_d)
            S_RESET_ALL, S_WAIT_LOCK, S_SETTLE, S_FAULT: rstn_d = '0;
            S_WAIT_DONE: begin
                if (state_q == S_RELEASE)
                    rstn_d = rstn_q | (NUM_STAGES'(1) << idx_q);
            end
            S_DONE: rstn_d = '1;
            default: ;
        endcase
    end

    assign stage_resetn = rstn_q;
    assign seq_done     = done_q;
    assign seq_fault    = fault_q;
    assign seq_state    = state_q;
    assign retry_cnt    = retry_q;

endmodule
